proc_ctrl_unit: RTL and testbench
=================================

# proc_ctrl_unit

Parametrised control unit for the next-generation Lab B programmable processor. Owns the program counter, instruction register and the fetch/decode/execute state machine, and drives all datapath control strobes (instruction ROM, data RAM, register file, ALU). It generalises the fixed 16-bit, 32-word controller in four ways:
- width and depth are parameters;
- adds a conditional jump (JMPZ);
- adds an illegal-opcode trap;
- adds a run/single-step debug mode.

## Interface
Parameters:
- PC_W, 5, program-counter width; program depth is 2^PC_W words
- OP_W, 4, opcode field width
- RF_AW, 4, register-file address width
- DA_W, 8, data-memory address field width; must satisfy DA_W >= 2*RF_AW and DA_W >= PC_W
- IW, OP_W+RF_AW+DA_W (16), instruction width; derived, not overridable

Ports:
- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-low reset
- Run  in  1  1 = free-run; 0 = single-step
- Step  in  1  single-cycle pulse; releases one instruction when Run=0
- InstrIn  in  IW  instruction ROM data, combinational on PC_Out
- RaZero  in  1  datapath flag: register-file read port A data == 0
- PC_Out  out  PC_W  program counter (ROM address)
- IR_Out  out  IW  instruction register
- StateO  out  4  current state encoding
- D_Addr  out  DA_W  data RAM address
- D_Rd, D_Wr  out  1 each  data RAM read / write strobes
- RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr  out  RF_AW each  register-file addresses
- RF_W_en  out  1  register-file write enable
- RF_s  out  1  write-data select: 1 = RAM data, 0 = ALU result
- ALU_s  out  2  ALU op: 00 pass A, 01 add, 10 sub
- Halted  out  1  sticky; set in HALT or TRAP
- Err  out  1  sticky; set only in TRAP

## Operation
Instruction fields:
- op = IR[IW-1 -: OP_W]
- rd = next RF_AW bits
- addr = low DA_W bits
- ra = addr[2*RF_AW-1:RF_AW]
- rb = addr[RF_AW-1:0]

| Opcode | Mnemonic | Effect |
|---|---|---|
| 0 | NOOP | none |
| 1 | STORE | M[addr] = R[rd] |
| 2 | LOAD | R[rd] = M[addr] |
| 3 | ADD | R[rd] = R[ra] + R[rb] |
| 4 | SUB | R[rd] = R[ra] − R[rb] |
| 5 | HALT | stop |
| 6 | JMPZ | if R[rd] == 0 then PC = addr[PC_W-1:0] |
| others | — | illegal |

States and StateO encoding: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9, JMPZ=10, TRAP=11.

Transitions:
- Reset asserted: go to INIT.
- INIT → FETCH, unconditionally.
- FETCH: instruction accepted when Run=1, or when Run=0 and Step=1. On acceptance: IR <= InstrIn, PC <= PC+1 (mod 2^PC_W), then → DECODE. Otherwise hold FETCH with IR and PC unchanged.
- DECODE → state selected by op; illegal op → TRAP.
- NOOP, STORE, ADD, SUB, JMPZ, LOAD_B → FETCH.
- LOAD_A → LOAD_B.
- HALT and TRAP: absorbing until reset.

Strobes (all combinational from state and IR; default 0 / address 0):
- STORE: D_Addr=addr, D_Wr=1, RF_Ra_Addr=rd
- LOAD_A: D_Addr=addr, D_Rd=1
- LOAD_B: D_Addr=addr, D_Rd=1, RF_s=1, RF_W_Addr=rd, RF_W_en=1
- ADD / SUB: RF_Ra_Addr=ra, RF_Rb_Addr=rb, RF_W_Addr=rd, RF_W_en=1, ALU_s=01 / 10
- JMPZ: RF_Ra_Addr=rd; when RaZero=1, PC <= addr[PC_W-1:0] at the state's closing edge
- HALT: Halted=1
- TRAP: Halted=1, Err=1

## Timing
- Reset values: PC_Out=0, IR_Out=0, StateO=0, Halted=0, Err=0, all strobes 0. Reset assertion mid-instruction aborts immediately (asynchronous), including mid-LOAD; no write strobe stays high after the reset edge.
- Instruction latency, FETCH to next FETCH in free-run:
  - 3 cycles: NOOP, STORE, ADD, SUB, JMPZ
  - 4 cycles: LOAD
- First FETCH occurs 1 cycle after reset release.
- PC wrap: fetch at PC = 2^PC_W−1 sets PC to 0.
- A JMPZ target overrides the FETCH increment. A jump to its own address is legal and loops.
- Step is sampled only in FETCH. Step pulses in other states are ignored, never queued. Step held high for N cycles in FETCH with Run=0 accepts exactly one instruction per FETCH visit.
- Run may change in any cycle. It takes effect at the next FETCH only.
- Write strobes (D_Wr, RF_W_en) are high for exactly one cycle per instruction.

## Structure
- Shared package proc_pkg: opcode constants, state encoding constants, ALU_s codes. The datapath and benches import the same package.
- One sub-module, proc_pc_reg (PC_W): async active-low clear, load, increment, hold. Load has priority over increment.
- The top module holds the state register, IR register and the combinational strobe decoder.

## Test plan
- Reset then free-run on ROM {LOAD R0←M[0x00], LOAD R1←M[0x01], ADD R2=R0+R1, STORE M[0x02]←R2, HALT}:
  - LOAD_B writes RF_W_Addr 0 then 1
  - ADD asserts ALU_s=01, RF_W_Addr=2
  - STORE asserts D_Wr with D_Addr=0x02
  - StateO ends at 9; Halted=1; PC_Out=5
- JMPZ R3 to 0x07: with RaZero=1, PC_Out=7 at the next FETCH; with RaZero=0, PC_Out=old PC+1.
- Opcode 0xF at PC 0: after DECODE, StateO=11, Err=1, Halted=1; state and outputs remain there for 20 cycles.
- Run=0 with NOOP program:
  - no Step → PC_Out stays 0 and StateO stays 1
  - Step held 5 cycles → PC_Out becomes exactly 1
- PC_W=3 with all NOOPs: PC_Out sequence 0..7 then 0; one increment every 3 cycles.
- Reset asserted during LOAD_A: within the same cycle StateO=0, D_Rd=0, PC_Out=0; first FETCH 1 cycle after release.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the Lab B processor: opcodes, controller state encoding, ALU codes.
// The controller, the datapath and the benches all import this package.
package proc_pkg;

   typedef enum logic [3:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_NOOP   = 4'd3,
      ST_LOAD_A = 4'd4,
      ST_LOAD_B = 4'd5,
      ST_STORE  = 4'd6,
      ST_ADD    = 4'd7,
      ST_SUB    = 4'd8,
      ST_HALT   = 4'd9,
      ST_JMPZ   = 4'd10,
      ST_TRAP   = 4'd11
   } state_t;

   localparam int unsigned OPC_NOOP  = 0;
   localparam int unsigned OPC_STORE = 1;
   localparam int unsigned OPC_LOAD  = 2;
   localparam int unsigned OPC_ADD   = 3;
   localparam int unsigned OPC_SUB   = 4;
   localparam int unsigned OPC_HALT  = 5;
   localparam int unsigned OPC_JMPZ  = 6;

   localparam logic [1:0] ALU_PASS_A = 2'b00;
   localparam logic [1:0] ALU_ADD    = 2'b01;
   localparam logic [1:0] ALU_SUB    = 2'b10;

   function automatic state_t decode_op(input int unsigned op);
      state_t st;
      case (op)
         OPC_NOOP:  st = ST_NOOP;
         OPC_STORE: st = ST_STORE;
         OPC_LOAD:  st = ST_LOAD_A;
         OPC_ADD:   st = ST_ADD;
         OPC_SUB:   st = ST_SUB;
         OPC_HALT:  st = ST_HALT;
         OPC_JMPZ:  st = ST_JMPZ;
         default:   st = ST_TRAP;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/proc_pc_reg.sv
// Program counter register: async clear, parallel load (jump target) with priority over increment.
module proc_pc_reg #(
   parameter int PC_W = 5
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Load,
   input  logic            Inc,
   input  logic [PC_W-1:0] D,
   output logic [PC_W-1:0] Q
);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         Q <= '0;
      else if (Load)
         Q <= D;
      else if (Inc)
         Q <= Q + 1'b1;
   end

endmodule

// File: rtl/proc_ctrl_unit.sv
// Lab B processor control unit: PC, IR, fetch/decode/execute FSM and datapath strobe decode.
//
// state   | meaning
// INIT    | post-reset, one cycle
// FETCH   | wait for Run or Step, latch IR, bump PC
// DECODE  | dispatch on opcode
// NOOP    | no operation
// LOAD_A  | RAM read address phase
// LOAD_B  | RAM data written into register file
// STORE   | register rd written to RAM
// ADD/SUB | ALU result written to register rd
// HALT    | stopped until reset
// JMPZ    | load PC with target when R[rd]==0
// TRAP    | illegal opcode, stopped until reset
module proc_ctrl_unit
   import proc_pkg::*;
#(
   parameter  int PC_W  = 5,
   parameter  int OP_W  = 4,
   parameter  int RF_AW = 4,
   parameter  int DA_W  = 8,
   localparam int IW    = OP_W + RF_AW + DA_W
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic             Step,
   input  logic [IW-1:0]    InstrIn,
   input  logic             RaZero,
   output logic [PC_W-1:0]  PC_Out,
   output logic [IW-1:0]    IR_Out,
   output logic [3:0]       StateO,
   output logic [DA_W-1:0]  D_Addr,
   output logic             D_Rd,
   output logic             D_Wr,
   output logic [RF_AW-1:0] RF_Ra_Addr,
   output logic [RF_AW-1:0] RF_Rb_Addr,
   output logic [RF_AW-1:0] RF_W_Addr,
   output logic             RF_W_en,
   output logic             RF_s,
   output logic [1:0]       ALU_s,
   output logic             Halted,
   output logic             Err
);

   state_t            state, state_nxt;
   logic [IW-1:0]     ir;
   logic              step_armed, step_armed_nxt;
   logic              accept;

   logic [OP_W-1:0]   op;
   logic [RF_AW-1:0]  rd, ra, rb;
   logic [DA_W-1:0]   addr;

   assign op   = ir[IW-1 -: OP_W];
   assign rd   = ir[DA_W +: RF_AW];
   assign addr = ir[DA_W-1:0];
   assign ra   = addr[2*RF_AW-1:RF_AW];
   assign rb   = addr[RF_AW-1:0];

   // A held Step releases only one instruction; it must drop low before it can release another.
   assign accept = (state == ST_FETCH) && (Run || (Step && step_armed));

   always_comb begin
      step_armed_nxt = step_armed;
      if (!Step)
         step_armed_nxt = 1'b1;
      else if (state == ST_FETCH)
         step_armed_nxt = 1'b0;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= ST_INIT;
         ir         <= '0;
         step_armed <= 1'b1;
      end else begin
         state      <= state_nxt;
         step_armed <= step_armed_nxt;
         if (accept)
            ir <= InstrIn;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT:   state_nxt = ST_FETCH;
         ST_FETCH:  if (accept) state_nxt = ST_DECODE;
         ST_DECODE: state_nxt = decode_op(32'(op));
         ST_LOAD_A: state_nxt = ST_LOAD_B;
         ST_NOOP, ST_STORE, ST_ADD, ST_SUB, ST_JMPZ, ST_LOAD_B:
                    state_nxt = ST_FETCH;
         ST_HALT:   state_nxt = ST_HALT;
         ST_TRAP:   state_nxt = ST_TRAP;
         default:   state_nxt = ST_TRAP;
      endcase
   end

   proc_pc_reg #(.PC_W(PC_W)) u_pc (
      .Clk   (Clk),
      .Reset (Reset),
      .Load  ((state == ST_JMPZ) && RaZero),
      .Inc   (accept),
      .D     (addr[PC_W-1:0]),
      .Q     (PC_Out)
   );

   always_comb begin
      D_Addr     = '0;
      D_Rd       = 1'b0;
      D_Wr       = 1'b0;
      RF_Ra_Addr = '0;
      RF_Rb_Addr = '0;
      RF_W_Addr  = '0;
      RF_W_en    = 1'b0;
      RF_s       = 1'b0;
      ALU_s      = ALU_PASS_A;
      Halted     = 1'b0;
      Err        = 1'b0;
      case (state)
         ST_STORE: begin
            D_Addr     = addr;
            D_Wr       = 1'b1;
            RF_Ra_Addr = rd;
         end
         ST_LOAD_A: begin
            D_Addr = addr;
            D_Rd   = 1'b1;
         end
         ST_LOAD_B: begin
            D_Addr    = addr;
            D_Rd      = 1'b1;
            RF_s      = 1'b1;
            RF_W_Addr = rd;
            RF_W_en   = 1'b1;
         end
         ST_ADD, ST_SUB: begin
            RF_Ra_Addr = ra;
            RF_Rb_Addr = rb;
            RF_W_Addr  = rd;
            RF_W_en    = 1'b1;
            ALU_s      = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
         end
         ST_JMPZ:   RF_Ra_Addr = rd;
         ST_HALT:   Halted = 1'b1;
         ST_TRAP: begin
            Halted = 1'b1;
            Err    = 1'b1;
         end
         default: ;
      endcase
   end

   assign IR_Out = ir;
   assign StateO = state;

endmodule

// File: tb/tb_proc_ctrl_unit.sv
// Directed bench for proc_ctrl_unit: default-width instance plus a PC_W=3 instance for wrap checks.
module tb_proc_ctrl_unit;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        Run = 1'b1;
   logic        Step = 1'b0;
   logic        RaZero = 1'b0;
   logic [15:0] rom [32];

   logic [15:0] InstrIn;
   logic [4:0]  PC_Out;
   logic [15:0] IR_Out;
   logic [3:0]  StateO;
   logic [7:0]  D_Addr;
   logic        D_Rd, D_Wr, RF_W_en, RF_s, Halted, Err;
   logic [3:0]  RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr;
   logic [1:0]  ALU_s;

   logic        run_2 = 1'b1;
   logic [2:0]  pc_2;
   logic [15:0] ir_2;
   logic [3:0]  state_2, ra_2, rb_2, wa_2;
   logic [7:0]  daddr_2;
   logic        drd_2, dwr_2, wen_2, rfs_2, halted_2, err_2;
   logic [1:0]  alu_2;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   assign InstrIn = rom[PC_Out];

   proc_ctrl_unit dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Step(Step), .InstrIn(InstrIn), .RaZero(RaZero),
      .PC_Out(PC_Out), .IR_Out(IR_Out), .StateO(StateO), .D_Addr(D_Addr), .D_Rd(D_Rd),
      .D_Wr(D_Wr), .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr), .RF_W_Addr(RF_W_Addr),
      .RF_W_en(RF_W_en), .RF_s(RF_s), .ALU_s(ALU_s), .Halted(Halted), .Err(Err)
   );

   proc_ctrl_unit #(.PC_W(3)) dut_w3 (
      .Clk(Clk), .Reset(Reset), .Run(run_2), .Step(1'b0), .InstrIn(16'h0000), .RaZero(1'b0),
      .PC_Out(pc_2), .IR_Out(ir_2), .StateO(state_2), .D_Addr(daddr_2), .D_Rd(drd_2),
      .D_Wr(dwr_2), .RF_Ra_Addr(ra_2), .RF_Rb_Addr(rb_2), .RF_W_Addr(wa_2),
      .RF_W_en(wen_2), .RF_s(rfs_2), .ALU_s(alu_2), .Halted(halted_2), .Err(err_2)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
   endtask

   // Leaves reset released 1 ns after an edge; the next edge moves INIT to FETCH.
   task automatic do_reset();
      Reset = 1'b0;
      tick();
      tick();
      Reset = 1'b1;
   endtask

   int exp_seq [17] = '{1, 2, 4, 5, 1, 2, 4, 5, 1, 2, 7, 1, 2, 6, 1, 2, 9};
   int lb_cnt, dwr_cnt, rfw_cnt;

   initial begin
      clear_rom();
      // ---- reset values ----
      #2;
      tick();
      check_val("rst_state",  32'(StateO), 32'd0);
      check_val("rst_pc",     32'(PC_Out), 32'd0);
      check_val("rst_ir",     32'(IR_Out), 32'd0);
      check_val("rst_halted", 32'(Halted), 32'd0);
      check_val("rst_err",    32'(Err), 32'd0);
      check_val("rst_strobes", 32'({D_Rd, D_Wr, RF_W_en, RF_s, ALU_s, D_Addr}), 32'd0);

      // ---- LOAD, LOAD, ADD, STORE, HALT ----
      rom[0] = 16'h2000;
      rom[1] = 16'h2101;
      rom[2] = 16'h3201;
      rom[3] = 16'h1202;
      rom[4] = 16'h5000;
      Run = 1'b1;
      do_reset();
      lb_cnt = 0; dwr_cnt = 0; rfw_cnt = 0;
      for (int i = 0; i < 17; i++) begin
         tick();
         dwr_cnt += int'(D_Wr);
         rfw_cnt += int'(RF_W_en);
         check_val($sformatf("prog_state[%0d]", i), 32'(StateO), 32'(exp_seq[i]));
         if (exp_seq[i] == 5) begin
            check_val("loadb_waddr", 32'(RF_W_Addr), 32'(lb_cnt));
            check_val("loadb_wen_rfs_rd", 32'({RF_W_en, RF_s, D_Rd}), 32'h7);
            lb_cnt++;
         end else if (exp_seq[i] == 7) begin
            check_val("add_alu_s", 32'(ALU_s), 32'd1);
            check_val("add_waddr", 32'(RF_W_Addr), 32'd2);
            check_val("add_ra_rb", 32'({RF_Ra_Addr, RF_Rb_Addr}), 32'h01);
         end else if (exp_seq[i] == 6) begin
            check_val("store_dwr", 32'(D_Wr), 32'd1);
            check_val("store_daddr", 32'(D_Addr), 32'h02);
            check_val("store_ra", 32'(RF_Ra_Addr), 32'd2);
         end
      end
      repeat (3) begin
         tick();
         dwr_cnt += int'(D_Wr);
         rfw_cnt += int'(RF_W_en);
      end
      check_val("prog_end_state", 32'(StateO), 32'd9);
      check_val("prog_halted", 32'(Halted), 32'd1);
      check_val("prog_err", 32'(Err), 32'd0);
      check_val("prog_pc", 32'(PC_Out), 32'd5);
      check_val("prog_dwr_cycles", 32'(dwr_cnt), 32'd1);
      check_val("prog_rfw_cycles", 32'(rfw_cnt), 32'd3);

      // ---- JMPZ R3 -> 0x07, taken twice (self loop), then not taken ----
      clear_rom();
      rom[0] = 16'h6307;
      rom[7] = 16'h6307;
      RaZero = 1'b1;
      do_reset();
      tick(); tick(); tick();
      check_val("jmpz_state", 32'(StateO), 32'd10);
      check_val("jmpz_ra", 32'(RF_Ra_Addr), 32'd3);
      tick();
      check_val("jmpz_taken_pc", 32'(PC_Out), 32'd7);
      check_val("jmpz_taken_state", 32'(StateO), 32'd1);
      tick(); tick(); tick();
      check_val("jmpz_loop_pc", 32'(PC_Out), 32'd7);
      RaZero = 1'b0;
      tick(); tick(); tick();
      check_val("jmpz_fall_pc", 32'(PC_Out), 32'd8);
      check_val("jmpz_fall_state", 32'(StateO), 32'd1);

      // ---- illegal opcode trap ----
      clear_rom();
      rom[0] = 16'hF000;
      do_reset();
      tick(); tick(); tick();
      check_val("trap_state", 32'(StateO), 32'd11);
      check_val("trap_err_halt", 32'({Err, Halted}), 32'h3);
      for (int i = 0; i < 20; i++) begin
         tick();
         check_val("trap_hold", 32'({StateO, Err, Halted, RF_W_en, D_Wr, PC_Out}),
                   32'({4'd11, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1}));
      end

      // ---- single step on NOOP program ----
      clear_rom();
      Run = 1'b0;
      Step = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         check_val("ss_idle", 32'({PC_Out, StateO}), 32'({5'd0, 4'd1}));
      end
      Step = 1'b1;
      repeat (5) tick();
      Step = 1'b0;
      repeat (4) tick();
      check_val("ss_held_pc", 32'(PC_Out), 32'd1);
      check_val("ss_held_state", 32'(StateO), 32'd1);
      Step = 1'b1;
      tick();
      Step = 1'b0;
      check_val("ss_pulse_decode", 32'(StateO), 32'd2);
      Step = 1'b1;
      tick();
      Step = 1'b0;
      repeat (4) tick();
      check_val("ss_pulse_pc", 32'(PC_Out), 32'd2);
      check_val("ss_pulse_state", 32'(StateO), 32'd1);
      Run = 1'b1;
      tick();
      check_val("run_resume", 32'(StateO), 32'd2);

      // ---- PC_W=3 wrap on all-NOOP program ----
      do_reset();
      for (int k = 0; k < 10; k++) begin
         tick();
         check_val($sformatf("w3_fetch_pc[%0d]", k), 32'({state_2, pc_2}), 32'({4'd1, 3'(k % 8)}));
         tick();
         check_val($sformatf("w3_inc_pc[%0d]", k), 32'(pc_2), 32'((k + 1) % 8));
         tick();
      end

      // ---- reset during LOAD_A ----
      clear_rom();
      rom[0] = 16'h2455;
      do_reset();
      tick(); tick(); tick();
      check_val("la_state", 32'(StateO), 32'd4);
      check_val("la_drd", 32'({D_Rd, D_Addr}), 32'h155);
      #2;
      Reset = 1'b0;
      #1;
      check_val("la_rst_state", 32'(StateO), 32'd0);
      check_val("la_rst_strobes", 32'({D_Rd, D_Wr, RF_W_en, PC_Out}), 32'd0);
      tick();
      Reset = 1'b1;
      check_val("la_rel_state", 32'(StateO), 32'd0);
      tick();
      check_val("la_first_fetch", 32'({StateO, PC_Out}), 32'({4'd1, 5'd0}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
